// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding valid/ready request port to AXI4-Lite initiator.
// Define AXI_TIMEOUT_EN to abort transactions stalled for TIMEOUT_CYCLES.
module axi_lite_master_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic        req_instr,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  input  logic [1:0]  m_axi_bresp,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp
);

  typedef enum logic [2:0] {
    IDLE, WADDR, WRESP, RADDR, RDATA
  } state_t;

  state_t      state_q, state_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        req_ready_q, req_ready_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  arprot_q, arprot_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_done, w_done;

  assign aw_hs = awvalid_q & m_axi_awready;
  assign w_hs  = wvalid_q & m_axi_wready;
  assign b_hs  = bready_q & m_axi_bvalid;
  assign ar_hs = arvalid_q & m_axi_arready;
  assign r_hs  = rready_q & m_axi_rvalid;

  // Each channel is done if it already handshook or is handshaking now
  assign aw_done = ~awvalid_q | m_axi_awready;
  assign w_done  = ~wvalid_q | m_axi_wready;

`ifdef AXI_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          any_hs;

  assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;
`endif

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    req_ready_d = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    arprot_d    = arprot_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && !req_ready_q) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          wstrb_d  = req_wstrb;
          arprot_d = {req_instr, 2'b00};
          if (req_wstrb != 4'b0000) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
        end
      end
      WADDR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs) wvalid_d = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        if (b_hs) begin
          bready_d    = 1'b0;
          req_ready_d = 1'b1;
          err_d       = m_axi_bresp[1];
          state_d     = IDLE;
        end
      end
      RADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (r_hs) begin
          rready_d    = 1'b0;
          rdata_d     = m_axi_rdata;
          err_d       = m_axi_rresp[1];
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef AXI_TIMEOUT_EN
    cnt_d = '0;
    if (state_q != IDLE && !any_hs) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == TMAX) begin
        cnt_d       = '0;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        req_ready_d = 1'b1;
        err_d       = 1'b1;
        rdata_d     = 32'hDEADBEEF;
        state_d     = IDLE;
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      req_ready_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      arprot_q    <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      req_ready_q <= req_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      arprot_q    <= arprot_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

`ifdef AXI_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (!RSTb) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  logic unused_w;
  assign unused_w = ^{m_axi_bresp[0], m_axi_rresp[0]};
`else
  logic unused_w;
  assign unused_w = ^{m_axi_bresp[0], m_axi_rresp[0],
                      1'(TIMEOUT_CYCLES)};
`endif

  assign req_ready     = req_ready_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_err       = err_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = arprot_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Bench for axi_lite_master_bridge: random AXI-Lite slave with
// per-transaction stall knobs, checked against transaction-level expectations.
module tb_axi_lite_master_bridge;

  logic        CLK = 1'b0;
  logic        RSTb = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_instr = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic [1:0]  m_axi_bresp = '0;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;

  axi_lite_master_bridge dut (
    .CLK(CLK), .RSTb(RSTb),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_instr(req_instr),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave knobs and per-transaction observations
  int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic [31:0] s_rdata;
  logic [1:0]  s_bresp, s_rresp;
  bit          spur = 0;
  int          aw_n, w_n, b_n, ar_n, r_n;
  logic [31:0] got_awaddr, got_wdata, got_araddr;
  logic [3:0]  got_wstrb;
  logic [2:0]  got_awprot, got_arprot;
  bit          bv, rv, b_pend, r_pend, b_sent, r_sent;
  logic [31:0] last_rdata;

  task automatic arm(input int aww, ww, bw, arw, rw,
                     input logic [31:0] rd, input logic [1:0] br, rr);
    aw_wait = aww; w_wait = ww; b_wait = bw;
    ar_wait = arw; r_wait = rw;
    s_rdata = rd; s_bresp = br; s_rresp = rr;
    aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
    bv = 0; rv = 0; b_pend = 0; r_pend = 0;
    b_sent = 0; r_sent = 0;
    got_awaddr = '0; got_wdata = '0; got_araddr = '0;
    got_wstrb = '0; got_awprot = '0; got_arprot = '0;
  endtask

  // Decisions at negedge hold through the next posedge, so a valid&ready
  // pair seen here is a handshake on the coming edge.
  initial begin
    arm(0, 0, 0, 0, 0, '0, '0, '0);
    forever begin
      @(negedge CLK);
      if (b_pend) begin bv = 0; b_sent = 1; b_pend = 0; end
      if (r_pend) begin rv = 0; r_sent = 1; r_pend = 0; end
      if (aw_n > 0 && w_n > 0 && !b_sent && !bv) begin
        if (b_wait > 0) b_wait--; else bv = 1;
      end
      if (ar_n > 0 && !r_sent && !rv) begin
        if (r_wait > 0) r_wait--; else rv = 1;
      end
      m_axi_awready = 1'b0;
      if (m_axi_awvalid) begin
        if (aw_wait > 0) aw_wait--;
        else begin
          m_axi_awready = 1'b1; aw_n++;
          got_awaddr = m_axi_awaddr; got_awprot = m_axi_awprot;
        end
      end
      m_axi_wready = 1'b0;
      if (m_axi_wvalid) begin
        if (w_wait > 0) w_wait--;
        else begin
          m_axi_wready = 1'b1; w_n++;
          got_wdata = m_axi_wdata; got_wstrb = m_axi_wstrb;
        end
      end
      m_axi_arready = 1'b0;
      if (m_axi_arvalid) begin
        if (ar_wait > 0) ar_wait--;
        else begin
          m_axi_arready = 1'b1; ar_n++;
          got_araddr = m_axi_araddr; got_arprot = m_axi_arprot;
        end
      end
      m_axi_bvalid = bv | spur;
      m_axi_bresp  = s_bresp;
      m_axi_rvalid = rv | spur;
      m_axi_rdata  = s_rdata;
      m_axi_rresp  = s_rresp;
      if (bv && m_axi_bready) begin b_n++; b_pend = 1; end
      if (rv && m_axi_rready) begin r_n++; r_pend = 1; end
    end
  end

  // Issue one request and compare its outcome with what the protocol implies.
  task automatic do_txn(input logic [31:0] a, d, input logic [3:0] s,
                        input logic ins, input int aww, ww, bw, arw, rw,
                        input logic [31:0] rd, input logic [1:0] rs,
                        input int exp_lat);
    int n;
    bit done;
    arm(aww, ww, bw, arw, rw, rd, rs, rs);
    req_valid = 1'b1; req_addr = a; req_wdata = d;
    req_wstrb = s; req_instr = ins;
    n = 0; done = 0;
    while (!done && n < 200) begin
      @(posedge CLK); #1;
      n++;
      done = req_ready;
    end
    req_valid = 1'b0;
    chk("done", 32'(done), 1);
    if (exp_lat != 0) chk("latency", n, exp_lat);
    chk("err", 32'(rsp_err), 32'(rs[1]));
    if (s != 4'b0000) begin
      chk("aw_cnt", aw_n, 1);
      chk("w_cnt", w_n, 1);
      chk("b_cnt", b_n, 1);
      chk("ar_cnt_w", ar_n, 0);
      chk("awaddr", got_awaddr, a);
      chk("awprot", 32'(got_awprot), 0);
      chk("wdata", got_wdata, d);
      chk("wstrb", 32'(got_wstrb), 32'(s));
      chk("rdata_keep", rsp_rdata, last_rdata);
    end else begin
      chk("ar_cnt", ar_n, 1);
      chk("r_cnt", r_n, 1);
      chk("aw_cnt_r", aw_n, 0);
      chk("araddr", got_araddr, a);
      chk("arprot", 32'(got_arprot), 32'({ins, 2'b00}));
      chk("rdata", rsp_rdata, rd);
      last_rdata = rd;
    end
  endtask

  initial begin
    int n;
    int pulses;
    logic [3:0] s;
    last_rdata = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 0);
    chk("rst_readies", 32'({m_axi_bready, m_axi_rready, req_ready}), 0);
    chk("rst_addr", m_axi_awaddr | m_axi_araddr, 0);
    chk("rst_wdata", m_axi_wdata, 0);
    chk("rst_strbprot", 32'({m_axi_wstrb, m_axi_awprot, m_axi_arprot}), 0);
    chk("rst_rsp", rsp_rdata | 32'(rsp_err), 0);
    RSTb = 1'b1;
    @(posedge CLK); #1;

    // Zero-wait read
    do_txn(32'h4, 0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h12345678, 2'b00, 3);
    @(posedge CLK); #1;
    chk("pulse_once", 32'(req_ready), 0);

    // W accepted 3 cycles before AW, SLVERR response
    do_txn(32'h0, 32'hCAFE0001, 4'hF, 0, 3, 0, 0, 0, 0, 0, 2'b10, 6);
    @(posedge CLK); #1;

    // Simultaneous AW/W acceptance
    do_txn(32'h10, 32'h55AA55AA, 4'h3, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3);
    @(posedge CLK); #1;

    // Back-to-back instruction fetches
    do_txn(32'h100, 0, 4'h0, 1, 0, 0, 0, 0, 0, 32'hA0000001, 2'b00, 3);
    for (int i = 1; i < 4; i++)
      do_txn(32'h100 + 32'(4 * i), 0, 4'h0, 1, 0, 0, 0, 0, 0,
             32'hA0000001 + 32'(i), 2'b00, 4);
    @(posedge CLK); #1;
    chk("b2b_idle", 32'(req_ready | m_axi_arvalid), 0);

    // Stray B/R responses while idle
    spur = 1;
    pulses = 0;
    repeat (3) begin
      @(posedge CLK); #1;
      if (req_ready) pulses++;
    end
    spur = 0;
    chk("stray_resp", pulses, 0);
    do_txn(32'h20, 0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h0BADF00D, 2'b11, 3);
    @(posedge CLK); #1;

    // Reset while waiting for R
    arm(0, 0, 0, 0, 10, 32'hAAAA5555, 2'b00, 2'b00);
    req_valid = 1'b1; req_addr = 32'h40; req_wstrb = 4'h0; req_instr = 0;
    n = 0;
    while (!m_axi_rready && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("in_rdata", 32'(m_axi_rready), 1);
    RSTb = 1'b0; req_valid = 1'b0;
    @(posedge CLK); #1;
    chk("rst_rready", 32'(m_axi_rready), 0);
    chk("rst_arvalid", 32'(m_axi_arvalid), 0);
    chk("rst_rdata0", rsp_rdata, 0);
    RSTb = 1'b1;
    last_rdata = '0;
    pulses = 0;
    repeat (14) begin
      if (req_ready) pulses++;
      @(posedge CLK); #1;
    end
    chk("rst_no_pulse", pulses, 0);
    do_txn(32'h44, 0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h600DF00D, 2'b00, 3);
    @(posedge CLK); #1;

    // Random mix with random stalls and responses
    for (int i = 0; i < 60; i++) begin
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      do_txn($urandom, $urandom, s, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom,
             2'($urandom_range(0, 3)), 0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge CLK); #1;
        chk("rnd_pulse", 32'(req_ready), 0);
      end
    end
    @(posedge CLK); #1;

`ifdef AXI_TIMEOUT_EN
    arm(0, 0, 0, 100000, 0, '0, 2'b00, 2'b00);
    req_valid = 1'b1; req_addr = 32'h80; req_wstrb = 4'h0;
    n = 0;
    while (!req_ready && n < 400) begin
      @(posedge CLK); #1;
      n++;
    end
    req_valid = 1'b0;
    chk("to_done", 32'(req_ready), 1);
    chk("to_err", 32'(rsp_err), 1);
    chk("to_rdata", rsp_rdata, 32'hDEADBEEF);
    @(posedge CLK); #1;
    chk("to_arvalid", 32'(m_axi_arvalid), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_bridge.md
Name: axi_lite_master_bridge

Overview:
AXI4-Lite initiator that converts a simple single-outstanding valid/ready request port (CPU or DMA side) into AXI4-Lite read or write transactions. It drives the register and memory responder ports of SlurmBoy peripherals such as the QSPI flash controller. There is one transaction in flight at a time, with independent AW/W handshakes, and errors are reported from BRESP/RRESP.

Parameters:
TIMEOUT_CYCLES, 255, number of cycles without any AXI handshake before abort. Used only when AXI_TIMEOUT_EN is defined.

Ports:
CLK  in  1  clock
RSTb  in  1  reset
req_valid  in  1  request pending; held until req_ready pulse
req_ready  out  1  one-cycle completion pulse
req_addr  in  32  byte address
req_wdata  in  32  write data
req_wstrb  in  4  byte enables; 4'b0000 = read, nonzero = write
req_instr  in  1  instruction fetch; drives arprot[2]
rsp_rdata  out  32  read data, valid during req_ready pulse
rsp_err  out  1  SLVERR/DECERR (resp[1]) or timeout, valid during req_ready pulse
m_axi_awvalid out 1; m_axi_awready in 1; m_axi_awaddr out 32; m_axi_awprot out 3
m_axi_wvalid out 1; m_axi_wready in 1; m_axi_wdata out 32; m_axi_wstrb out 4
m_axi_bvalid in 1; m_axi_bready out 1; m_axi_bresp in 2
m_axi_arvalid out 1; m_axi_arready in 1; m_axi_araddr out 32; m_axi_arprot out 3
m_axi_rvalid in 1; m_axi_rready out 1; m_axi_rdata in 32; m_axi_rresp in 2

Behaviour:
- Reset is synchronous and active-low on RSTb (sampled at posedge CLK). All valid, ready and req_ready outputs are 0. Addr, data, strb, prot, rsp_rdata and rsp_err are 0. The state is IDLE.
- States: IDLE, WADDR (AW and/or W pending), WRESP, RADDR, RDATA.
- IDLE: request is accepted when req_valid=1 and req_ready=0. This blocks re-accept in the completion cycle.
  - On accept, register addr, wdata, wstrb and prot. Outputs are registered with no combinational path from req_* to m_axi_*.
- Write (wstrb≠0): next cycle awvalid=1 and wvalid=1, state WADDR.
  - awvalid drops on the edge where awvalid&awready; wvalid drops on wvalid&wready. The two handshakes complete independently and in either order.
  - When both are done (including the same cycle), go to WRESP with bready=1.
  - On bvalid&bready: bready=0, req_ready=1 for one cycle, rsp_err=bresp[1], rsp_rdata unchanged. Return to IDLE.
- Read (wstrb=0): next cycle arvalid=1, state RADDR.
  - On arvalid&arready: arvalid=0, rready=1, state RDATA.
  - On rvalid&rready: rready=0, rsp_rdata=rdata, rsp_err=rresp[1], req_ready=1 for one cycle. Return to IDLE.
- Prot values: awprot=3'b000; arprot={req_instr,2'b00}.
- Stability: addr, data and strb stay constant while their valid is high; valid is never withdrawn before its handshake.
- Latency with a zero-wait slave (ready coincident with valid, response the cycle after): req_valid sampled at edge 0 → req_ready high in cycle 3, for both reads and writes.
- Back-to-back: the next request is accepted at the earliest on the edge after the req_ready cycle. One transaction is outstanding at most.
- rvalid or bvalid arriving outside RDATA or WRESP is ignored, since the corresponding ready is low.
- Reset mid-transaction: all valids and readies drop at the reset edge and the state goes to IDLE. No req_ready pulse is issued; the requester re-issues.

Optional Feature:
AXI_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears in IDLE and on every AXI handshake, and increments otherwise in non-IDLE states.
  - At TIMEOUT_CYCLES it aborts: all m_axi valids and readies go to 0, req_ready=1 for one cycle, rsp_err=1, rsp_rdata=32'hDEADBEEF. The state goes to IDLE.
  - A late bvalid or rvalid is then ignored.
- Undefined: no counter exists, the block waits indefinitely, and TIMEOUT_CYCLES is unused.

Test Plan:
1. Read, zero-wait slave: addr 0x0000_0004, rdata 0x1234_5678, rresp 0 → arvalid cycle 1 with araddr 0x4, rready cycle 2, req_ready cycle 3 with rsp_rdata 0x1234_5678 and rsp_err 0.
2. Write where wready precedes awready by 3 cycles: addr 0x0, data 0xCAFE_0001, strb 0xF → wvalid drops after its handshake, awvalid held until awready, then bready, then req_ready; bresp 2'b10 gives rsp_err 1.
3. Slave asserts awready and wready in the same cycle → direct WADDR→WRESP in one edge; total latency 3 cycles.
4. Instruction fetch with req_instr=1 → arprot 3'b100; 4 back-to-back reads → exactly 4 req_ready pulses and no duplicate AR on the pulse cycle.
5. RSTb low while in RDATA → rready 0 next cycle, no req_ready, state IDLE; a subsequent read completes normally.
6. AXI_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready tied 0 → req_ready after 16 cycles with rsp_err 1 and rsp_rdata 0xDEADBEEF; arvalid low afterwards.
